step_rate_meter: RTL and testbench

STEP_RATE_METER -- requirements
Module: step_rate_meter

---
 rtl/step_rate_meter.sv | 183 ++++++++++++++++++
 tb/tb_step_rate_meter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_rate_meter.sv
// step_rate_meter: debounced step counter with a windowed step rate and an ACTIVE/IDLE tracker.
// Optional macro STEP_PEAK_RATE_EN adds a peak_rate output holding the highest window rate seen.
module step_rate_meter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,      // >= 1
    parameter int unsigned WINDOW_CYCLES   = 100000000, // >= 2
    parameter int unsigned IDLE_WINDOWS    = 2          // >= 1
) (
    input  logic        clk100Mhz,
    input  logic        rst_n,
    input  logic        pulse_in,
    input  logic        clear,
    output logic        step_valid,
    output logic [13:0] total_steps,
    output logic [7:0]  rate_out,
    output logic        rate_valid,
    output logic        active
`ifdef STEP_PEAK_RATE_EN
    ,
    output logic [7:0]  peak_rate
`endif
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int unsigned IDLE_W = $clog2(IDLE_WINDOWS + 1);

    localparam logic [13:0]       TOTAL_MAX = 14'd9999;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_WINDOWS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic              sync_meta;
    logic              sync_level;
    logic              db_level;
    logic              db_level_d;
    logic              db_level_d2;
    logic [DB_W-1:0]   db_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [7:0]        win_steps;
    logic              win_last;
    state_t            state;
    state_t            state_next;
    logic [IDLE_W-1:0] zero_cnt;
    logic [IDLE_W-1:0] zero_cnt_next;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source,
    // which is what turns these two statements into a two-stage shift rather than one wire.
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= pulse_in;
            sync_level <= sync_meta;
        end
    end

    // The debounced level is delayed twice before edge detection so a step lands
    // DEBOUNCE_CYCLES+3 cycles after the first sampling edge.
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            db_level    <= 1'b0;
            db_level_d  <= 1'b0;
            db_level_d2 <= 1'b0;
            db_cnt      <= '0;
            step_valid  <= 1'b0;
        end else begin
            if (sync_level != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync_level;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            db_level_d  <= db_level;
            db_level_d2 <= db_level_d;
            step_valid  <= db_level_d & ~db_level_d2;
        end
    end

    assign win_last = (win_cnt == WIN_LAST);

    // A step on the terminal cycle seeds the next window's count instead of the finished one.
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            total_steps <= '0;
            rate_out    <= '0;
            rate_valid  <= 1'b0;
            win_cnt     <= '0;
            win_steps   <= '0;
        end else if (clear) begin
            total_steps <= '0;
            rate_out    <= '0;
            rate_valid  <= 1'b0;
            win_cnt     <= '0;
            win_steps   <= '0;
        end else begin
            if (step_valid && total_steps != TOTAL_MAX) begin
                total_steps <= total_steps + 1'b1;
            end
            rate_valid <= win_last;
            if (win_last) begin
                win_cnt   <= '0;
                rate_out  <= win_steps;
                win_steps <= {7'd0, step_valid};
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (step_valid && win_steps != 8'hFF) begin
                    win_steps <= win_steps + 1'b1;
                end
            end
        end
    end

`ifdef STEP_PEAK_RATE_EN
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            peak_rate <= '0;
        end else if (clear) begin
            peak_rate <= '0;
        end else if (win_last && win_steps > peak_rate) begin
            peak_rate <= win_steps;
        end
    end
`endif

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            zero_cnt <= '0;
        end else begin
            state    <= state_next;
            zero_cnt <= zero_cnt_next;
        end
    end

    // NOTE: defaults first, so every path through the case assigns both outputs and no latch is inferred.
    always_comb begin
        state_next    = state;
        zero_cnt_next = zero_cnt;
        if (clear) begin
            state_next    = IDLE;
            zero_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        state_next    = ACTIVE;
                        zero_cnt_next = '0;
                    end
                end
                ACTIVE: begin
                    // A fresh step outranks an expiring idle count on the same cycle.
                    if (step_valid) begin
                        zero_cnt_next = '0;
                    end else if (win_last && win_steps == '0) begin
                        if (zero_cnt == IDLE_LAST) begin
                            state_next    = IDLE;
                            zero_cnt_next = '0;
                        end else begin
                            zero_cnt_next = zero_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next    = IDLE;
                    zero_cnt_next = '0;
                end
            endcase
        end
    end

    assign active = (state == ACTIVE);

endmodule

// File: tb/tb_step_rate_meter.sv
// Self-checking bench for step_rate_meter: directed scenarios plus random pulse trains
// compared against a history-based reference model of steps, windows and activity.
`timescale 1ns/1ps
module tb_step_rate_meter;

    localparam int D       = 4;
    localparam int W       = 100;
    localparam int IW      = 2;
    localparam int SAT_MAX = 9999;

    logic        clk100Mhz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        pulse_in  = 1'b0;
    logic        clear     = 1'b0;
    logic        step_valid;
    logic [13:0] total_steps;
    logic [7:0]  rate_out;
    logic        rate_valid;
    logic        active;

    logic        sat_pulse = 1'b0;
    logic        sat_clear = 1'b0;
    logic        sat_step_valid;
    logic [13:0] sat_total;
    logic [7:0]  sat_rate;
    logic        sat_rate_valid;
    logic        sat_active;
`ifdef STEP_PEAK_RATE_EN
    logic [7:0]  peak_rate;
    logic [7:0]  sat_peak;
    logic [7:0]  e_peak;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk100Mhz = ~clk100Mhz;

    step_rate_meter #(.DEBOUNCE_CYCLES(D), .WINDOW_CYCLES(W), .IDLE_WINDOWS(IW)) u_dut (
        .clk100Mhz(clk100Mhz), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
        .step_valid(step_valid), .total_steps(total_steps), .rate_out(rate_out),
        .rate_valid(rate_valid), .active(active)
`ifdef STEP_PEAK_RATE_EN
        , .peak_rate(peak_rate)
`endif
    );

    // Second instance with a one-cycle debouncer so ten thousand steps fit in a short run.
    step_rate_meter #(.DEBOUNCE_CYCLES(1), .WINDOW_CYCLES(W), .IDLE_WINDOWS(IW)) u_sat (
        .clk100Mhz(clk100Mhz), .rst_n(rst_n), .pulse_in(sat_pulse), .clear(sat_clear),
        .step_valid(sat_step_valid), .total_steps(sat_total), .rate_out(sat_rate),
        .rate_valid(sat_rate_valid), .active(sat_active)
`ifdef STEP_PEAK_RATE_EN
        , .peak_rate(sat_peak)
`endif
    );

    // Reference model: expected outputs after each rising edge of clk100Mhz.
    bit          samp[$];
    int          due[$];
    int          k;
    bit          m_db;
    bit          e_step;
    bit          e_rv;
    bit          e_active;
    logic [13:0] e_total;
    logic [7:0]  e_rate;
    int          e_wpos;
    int          e_wcount;
    int          e_zeros;

    function automatic bit s_at(int idx);
        if (idx < 0 || idx >= samp.size()) return 1'b0;
        return samp[idx];
    endfunction

    task automatic model_reset();
        samp.delete();
        due.delete();
        k        = -1;
        m_db     = 1'b0;
        e_step   = 1'b0;
        e_rv     = 1'b0;
        e_active = 1'b0;
        e_total  = '0;
        e_rate   = '0;
        e_wpos   = 0;
        e_wcount = 0;
        e_zeros  = 0;
`ifdef STEP_PEAK_RATE_EN
        e_peak   = '0;
`endif
    endtask

    task automatic model_edge();
        bit prev_step;
        bit flip;
        bit terminal;
        bit was_zero;
        k++;
        samp.push_back(pulse_in);
        // The level flips once the D samples seen behind the two-flop synchroniser all disagree with it.
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
            if (s_at(k - j) == m_db) flip = 1'b0;
        end
        if (flip) begin
            m_db = ~m_db;
            if (m_db) due.push_back(k + 2);
        end
        prev_step = e_step;
        e_step    = 1'b0;
        if (due.size() > 0 && due[0] == k) begin
            e_step = 1'b1;
            void'(due.pop_front());
        end
        if (clear) begin
            e_total  = '0;
            e_rate   = '0;
            e_rv     = 1'b0;
            e_wpos   = 0;
            e_wcount = 0;
            e_active = 1'b0;
            e_zeros  = 0;
`ifdef STEP_PEAK_RATE_EN
            e_peak   = '0;
`endif
        end else begin
            terminal = (e_wpos == W - 1);
            was_zero = (e_wcount == 0);
            if (prev_step && e_total < 14'(SAT_MAX)) e_total = e_total + 14'd1;
            e_rv = terminal;
            if (terminal) begin
                e_rate   = (e_wcount > 255) ? 8'd255 : 8'(e_wcount);
                e_wcount = prev_step ? 1 : 0;
                e_wpos   = 0;
`ifdef STEP_PEAK_RATE_EN
                if (e_rate > e_peak) e_peak = e_rate;
`endif
            end else begin
                e_wcount = e_wcount + (prev_step ? 1 : 0);
                e_wpos   = e_wpos + 1;
            end
            if (prev_step) begin
                e_active = 1'b1;
                e_zeros  = 0;
            end else if (e_active && terminal && was_zero) begin
                e_zeros++;
                if (e_zeros >= IW) begin
                    e_active = 1'b0;
                    e_zeros  = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk100Mhz or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    task automatic wait_wpos(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk100Mhz);
            if (e_wpos == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_window_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk100Mhz);
            if (e_rv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pulse_in = 1'b1;
        repeat (3) @(negedge clk100Mhz);
        checks++; if (step_valid !== 1'b0) begin failures++; $display("FAIL reset_step_valid got=%0b want=0", step_valid); end
        checks++; if (total_steps !== 14'd0) begin failures++; $display("FAIL reset_total got=%0d want=0", total_steps); end
        checks++; if (rate_out !== 8'd0) begin failures++; $display("FAIL reset_rate got=%0d want=0", rate_out); end
        checks++; if (rate_valid !== 1'b0) begin failures++; $display("FAIL reset_rate_valid got=%0b want=0", rate_valid); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b want=0", active); end
        checks++; if (sat_total !== 14'd0) begin failures++; $display("FAIL reset_sat_total got=%0d want=0", sat_total); end
        pulse_in = 1'b0;
        @(negedge clk100Mhz);
        rst_n = 1'b1;
    endtask

    task automatic test_first_step();
        pulse_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk100Mhz);
            checks++; if (step_valid !== (i == D + 3)) begin failures++; $display("FAIL first_step_timing edge=%0d got=%0b want=%0b", i, step_valid, (i == D + 3)); end
        end
        pulse_in = 1'b0;
        checks++; if (total_steps !== 14'd1) begin failures++; $display("FAIL first_step_total got=%0d want=1", total_steps); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL first_step_active got=%0b want=1", active); end
        repeat (12) @(negedge clk100Mhz);
    endtask

    task automatic test_glitch();
        pulse_in = 1'b1;
        repeat (3) @(negedge clk100Mhz);
        pulse_in = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk100Mhz);
            checks++; if (step_valid !== 1'b0) begin failures++; $display("FAIL glitch_step cycle=%0d got=%0b want=0", i, step_valid); end
        end
        checks++; if (total_steps !== 14'd1) begin failures++; $display("FAIL glitch_total got=%0d want=1", total_steps); end
    endtask

    task automatic test_window_rate();
        bit ok;
        wait_wpos(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL window_rate_sync got=timeout want=wpos2"); end
        for (int p = 0; p < 5; p++) begin
            pulse_in = 1'b1;
            repeat (6) @(negedge clk100Mhz);
            pulse_in = 1'b0;
            repeat (6) @(negedge clk100Mhz);
        end
        wait_window_end(ok);
        checks++; if (!ok || rate_valid !== 1'b1) begin failures++; $display("FAIL window_rate_valid got=%0b want=1", rate_valid); end
        checks++; if (rate_out !== 8'd5) begin failures++; $display("FAIL window_rate_five got=%0d want=5", rate_out); end
        @(negedge clk100Mhz);
        checks++; if (rate_valid !== 1'b0) begin failures++; $display("FAIL window_rate_pulse_width got=%0b want=0", rate_valid); end
        checks++; if (rate_out !== 8'd5) begin failures++; $display("FAIL window_rate_hold got=%0d want=5", rate_out); end
        wait_window_end(ok);
        checks++; if (!ok || rate_valid !== 1'b1) begin failures++; $display("FAIL window_empty_valid got=%0b want=1", rate_valid); end
        checks++; if (rate_out !== 8'd0) begin failures++; $display("FAIL window_empty_rate got=%0d want=0", rate_out); end
    endtask

    task automatic test_terminal_step();
        bit ok;
        wait_wpos(W - 1 - (D + 4), ok);
        checks++; if (!ok) begin failures++; $display("FAIL terminal_sync got=timeout want=wpos"); end
        pulse_in = 1'b1;
        repeat (D + 4) @(negedge clk100Mhz);
        pulse_in = 1'b0;
        checks++; if (step_valid !== 1'b1) begin failures++; $display("FAIL terminal_step_present got=%0b want=1", step_valid); end
        @(negedge clk100Mhz);
        checks++; if (rate_valid !== 1'b1) begin failures++; $display("FAIL terminal_end_valid got=%0b want=1", rate_valid); end
        checks++; if (rate_out !== 8'd0) begin failures++; $display("FAIL terminal_old_window got=%0d want=0", rate_out); end
        wait_window_end(ok);
        checks++; if (!ok || rate_out !== 8'd1) begin failures++; $display("FAIL terminal_new_window got=%0d want=1", rate_out); end
    endtask

    task automatic test_idle_timeout();
        bit ok;
        wait_wpos(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL idle_sync got=timeout want=wpos10"); end
        pulse_in = 1'b1;
        repeat (8) @(negedge clk100Mhz);
        pulse_in = 1'b0;
        wait_window_end(ok);
        checks++; if (!ok || rate_out !== 8'd1) begin failures++; $display("FAIL idle_step_window got=%0d want=1", rate_out); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL idle_after_step got=%0b want=1", active); end
        wait_window_end(ok);
        checks++; if (!ok || active !== 1'b1) begin failures++; $display("FAIL idle_first_zero got=%0b want=1", active); end
        wait_wpos(W - 1, ok);
        checks++; if (!ok || active !== 1'b1) begin failures++; $display("FAIL idle_before_second got=%0b want=1", active); end
        @(negedge clk100Mhz);
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL idle_second_zero got=%0b want=0", active); end
    endtask

    task automatic test_random();
        bit level;
        int left;
        level = 1'b0;
        left  = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk100Mhz);
            checks++; if (step_valid !== e_step) begin failures++; $display("FAIL rand_step cycle=%0d got=%0b want=%0b", c, step_valid, e_step); end
            checks++; if (total_steps !== e_total) begin failures++; $display("FAIL rand_total cycle=%0d got=%0d want=%0d", c, total_steps, e_total); end
            checks++; if (rate_out !== e_rate) begin failures++; $display("FAIL rand_rate cycle=%0d got=%0d want=%0d", c, rate_out, e_rate); end
            checks++; if (rate_valid !== e_rv) begin failures++; $display("FAIL rand_rate_valid cycle=%0d got=%0b want=%0b", c, rate_valid, e_rv); end
            checks++; if (active !== e_active) begin failures++; $display("FAIL rand_active cycle=%0d got=%0b want=%0b", c, active, e_active); end
`ifdef STEP_PEAK_RATE_EN
            checks++; if (peak_rate !== e_peak) begin failures++; $display("FAIL rand_peak cycle=%0d got=%0d want=%0d", c, peak_rate, e_peak); end
`endif
            if (left == 0) begin
                level = ~level;
                if (level) left = $urandom_range(1, 10);
                else if ($urandom_range(0, 7) == 0) left = $urandom_range(100, 250);
                else left = $urandom_range(1, 14);
            end
            left--;
            pulse_in = level;
            clear    = ($urandom_range(0, 249) == 0);
        end
        pulse_in = 1'b0;
        clear    = 1'b0;
        repeat (12) @(negedge clk100Mhz);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < SAT_MAX - 1; n++) begin
            sat_pulse = 1'b1;
            repeat (2) @(negedge clk100Mhz);
            sat_pulse = 1'b0;
            repeat (2) @(negedge clk100Mhz);
        end
        repeat (8) @(negedge clk100Mhz);
        checks++; if (sat_total !== 14'd9998) begin failures++; $display("FAIL sat_preload got=%0d want=9998", sat_total); end
        for (int n = 0; n < 3; n++) begin
            sat_pulse = 1'b1;
            repeat (2) @(negedge clk100Mhz);
            sat_pulse = 1'b0;
            repeat (8) @(negedge clk100Mhz);
            checks++; if (sat_total !== 14'd9999) begin failures++; $display("FAIL sat_hold step=%0d got=%0d want=9999", n, sat_total); end
        end
        checks++; if (sat_active !== 1'b1) begin failures++; $display("FAIL sat_active_before_clear got=%0b want=1", sat_active); end
        sat_clear = 1'b1;
        @(negedge clk100Mhz);
        sat_clear = 1'b0;
        checks++; if (sat_total !== 14'd0) begin failures++; $display("FAIL sat_clear_total got=%0d want=0", sat_total); end
        checks++; if (sat_active !== 1'b0) begin failures++; $display("FAIL sat_clear_active got=%0b want=0", sat_active); end
        checks++; if (sat_rate !== 8'd0) begin failures++; $display("FAIL sat_clear_rate got=%0d want=0", sat_rate); end
    endtask

    task automatic test_reset_mid_pulse();
        pulse_in = 1'b1;
        repeat (12) @(negedge clk100Mhz);
        checks++; if (total_steps === 14'd0) begin failures++; $display("FAIL midreset_pre_total got=%0d want=nonzero", total_steps); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (step_valid !== 1'b0) begin failures++; $display("FAIL midreset_step got=%0b want=0", step_valid); end
        checks++; if (total_steps !== 14'd0) begin failures++; $display("FAIL midreset_total got=%0d want=0", total_steps); end
        checks++; if (rate_out !== 8'd0) begin failures++; $display("FAIL midreset_rate got=%0d want=0", rate_out); end
        checks++; if (rate_valid !== 1'b0) begin failures++; $display("FAIL midreset_rate_valid got=%0b want=0", rate_valid); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%0b want=0", active); end
        @(negedge clk100Mhz);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk100Mhz);
            checks++; if (step_valid !== (i == D + 3)) begin failures++; $display("FAIL midreset_step_timing edge=%0d got=%0b want=%0b", i, step_valid, (i == D + 3)); end
        end
        pulse_in = 1'b0;
        checks++; if (total_steps !== 14'd1) begin failures++; $display("FAIL midreset_total_after got=%0d want=1", total_steps); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL midreset_active_after got=%0b want=1", active); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_glitch();
        test_window_rate();
        test_terminal_step();
        test_idle_timeout();
        test_random();
        test_saturation();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
